analizador_canal: RTL

ANALIZADOR_CANAL -- requirements
Module: analizador_canal

---
 rtl/analizador_canal_if.sv | 26 ++
 rtl/analizador_canal.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/analizador_canal_if.sv
// Channel-analyser bus: memory address/data plus start/busy/done handshake and result fields.
// master is the analyser side, slave is the memory/controller side.
interface analizador_canal_if #(
    parameter int M = 12
);
    logic           start;
    logic [9:0]     dir;
    logic [M-1:0]   data_in;
    logic           busy;
    logic           done;
    logic [M-1:0]   baseline;
    logic [M-1:0]   peak;
    logic [9:0]     peak_dir;
    logic [19:0]    charge;
    logic           trigger;

    modport master (
        input  start, data_in,
        output dir, busy, done, baseline, peak, peak_dir, charge, trigger
    );

    modport slave (
        output start, data_in,
        input  dir, busy, done, baseline, peak, peak_dir, charge, trigger
    );
endinterface

// File: rtl/analizador_canal.sv
// Scans one stored channel trace: baseline from the first N_BASE samples, then peak/charge/trigger.
// Results with a one-cycle done pulse 152 clocks after start; start is ignored (not queued) while a pass runs.
module analizador_canal #(
    parameter int M          = 12,
    parameter int N_MUESTRAS = 150,
    parameter int N_BASE     = 8,
    parameter int UMBRAL     = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    analizador_canal_if.master    bus
);

    localparam int          BSH  = $clog2(N_BASE);
    localparam int          SW   = M + BSH;
    localparam logic [9:0]  ULT  = 10'(N_MUESTRAS - 1);
    localparam logic [9:0]  PRIM = 10'(N_BASE);
    localparam logic [M:0]  UMB  = (M+1)'(UMBRAL);

    typedef enum logic [1:0] {IDLE, LECTURA, DRENAJE, FIN} estado_t;

    estado_t         estado_q, estado_d;
    logic [9:0]      dir_q, dir_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            drain_q, drain_d;
    logic            dir_vld_q, dir_vld_d;
    logic            dat_vld_q, dat_vld_d;
    logic [9:0]      dat_dir_q, dat_dir_d;
    logic [SW-1:0]   suma_q, suma_d;
    logic [M-1:0]    base_int_q, base_int_d;
    logic [M-1:0]    baseline_q, baseline_d;
    logic [M-1:0]    peak_q, peak_d;
    logic [9:0]      peak_dir_q, peak_dir_d;
    logic [19:0]     charge_q, charge_d;
    logic            trigger_q, trigger_d;
    logic [M-1:0]    exceso;
    logic            disparo;

    always_comb begin
        estado_d   = estado_q;
        dir_d      = dir_q;
        busy_d     = busy_q;
        done_d     = done_q;
        drain_d    = drain_q;
        suma_d     = suma_q;
        base_int_d = base_int_q;
        baseline_d = baseline_q;
        peak_d     = peak_q;
        peak_dir_d = peak_dir_q;
        charge_d   = charge_q;
        trigger_d  = trigger_q;
        exceso     = '0;
        // 13-bit compare so baseline + threshold cannot wrap past full scale
        disparo    = ({1'b0, peak_q} >= ({1'b0, base_int_q} + UMB));

        case (estado_q)
            IDLE: begin
                dir_d = '0;
                if (bus.start) begin
                    estado_d   = LECTURA;
                    busy_d     = 1'b1;
                    peak_d     = '0;
                    peak_dir_d = '0;
                    charge_d   = '0;
                    trigger_d  = 1'b0;
                    suma_d     = '0;
                    base_int_d = '0;
                end
            end
            LECTURA: begin
                if (dir_q == ULT) begin
                    estado_d = DRENAJE;
                    drain_d  = 1'b0;
                end else begin
                    dir_d = dir_q + 10'd1;
                end
            end
            DRENAJE: begin
                if (drain_q) begin
                    estado_d   = FIN;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    baseline_d = base_int_q;
                    trigger_d  = disparo;
                end else begin
                    drain_d = 1'b1;
                end
            end
            FIN: begin
                estado_d = IDLE;
                done_d   = 1'b0;
                dir_d    = '0;
            end
            default: estado_d = IDLE;
        endcase

        // dir_vld marks a requested address, dat_vld marks the matching read data one clock later
        dir_vld_d = (estado_d == LECTURA);
        dat_vld_d = dir_vld_q;
        dat_dir_d = dir_q;

        if (dat_vld_q) begin
            if (dat_dir_q < PRIM) begin
                suma_d = suma_q + SW'(bus.data_in);
                if (dat_dir_q == PRIM - 10'd1) begin
                    base_int_d = suma_d[BSH +: M];
                end
            end else begin
                if (bus.data_in > base_int_q) begin
                    exceso = bus.data_in - base_int_q;
                end
                charge_d = charge_q + 20'(exceso);
                if ((dat_dir_q == PRIM) || (bus.data_in > peak_q)) begin
                    peak_d     = bus.data_in;
                    peak_dir_d = dat_dir_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= IDLE;
            dir_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drain_q    <= 1'b0;
            dir_vld_q  <= 1'b0;
            dat_vld_q  <= 1'b0;
            dat_dir_q  <= '0;
            suma_q     <= '0;
            base_int_q <= '0;
            baseline_q <= '0;
            peak_q     <= '0;
            peak_dir_q <= '0;
            charge_q   <= '0;
            trigger_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drain_q    <= drain_d;
            dir_vld_q  <= dir_vld_d;
            dat_vld_q  <= dat_vld_d;
            dat_dir_q  <= dat_dir_d;
            suma_q     <= suma_d;
            base_int_q <= base_int_d;
            baseline_q <= baseline_d;
            peak_q     <= peak_d;
            peak_dir_q <= peak_dir_d;
            charge_q   <= charge_d;
            trigger_q  <= trigger_d;
        end
    end

    assign bus.dir      = dir_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.baseline = baseline_q;
    assign bus.peak     = peak_q;
    assign bus.peak_dir = peak_dir_q;
    assign bus.charge   = charge_q;
    assign bus.trigger  = trigger_q;

endmodule
